// File: rtl/regfile_scoreboard_pkg.sv
// Shared types for the integer register-file scoreboard.
// This covers register addressing, the busy-bit vector and the in-flight counter.
package regfile_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int CNT_W      = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NREG-1:0]       busy_vec_t;
  typedef logic [CNT_W-1:0]      count_t;

  // A destination is tracked only if a multi-cycle unit writes a real register.
  function automatic logic is_tracked(logic wen, logic is_long, reg_addr_t rd);
    return wen & is_long & (rd != '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-side bus of the scoreboard.
// Decode (master) presents an instruction and the writeback port; the scoreboard (slave) answers.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::reg_addr_t;

  logic      iss_valid;
  reg_addr_t iss_rs1c;
  reg_addr_t iss_rs2c;
  logic      iss_use_rs1;
  logic      iss_use_rs2;
  reg_addr_t iss_rdc;
  logic      iss_wen;
  logic      iss_long;
  logic      iss_ready;
  logic      wb_valid;
  reg_addr_t wb_rdc;
  logic      flush;
  logic      fwd_rs1;
  logic      fwd_rs2;

  modport master (
    output iss_valid, iss_rs1c, iss_rs2c, iss_use_rs1, iss_use_rs2,
    output iss_rdc, iss_wen, iss_long, wb_valid, wb_rdc, flush,
    input  iss_ready, fwd_rs1, fwd_rs2
  );

  modport slave (
    input  iss_valid, iss_rs1c, iss_rs2c, iss_use_rs1, iss_use_rs2,
    input  iss_rdc, iss_wen, iss_long, wb_valid, wb_rdc, flush,
    output iss_ready, fwd_rs1, fwd_rs2
  );

endinterface

// File: rtl/regfile_scoreboard_hazard.sv
// Combinational hazard/forward check for one register address against the busy
// vector and the writeback bus. BYPASS=1 lets a retiring producer resolve the hazard.
module regfile_scoreboard_hazard
  import regfile_scoreboard_pkg::reg_addr_t;
  import regfile_scoreboard_pkg::busy_vec_t;
#(
  parameter bit BYPASS = 1'b1
) (
  input  reg_addr_t addr,
  input  logic      use_addr,
  input  busy_vec_t busy_vec,
  input  logic      wb_valid,
  input  reg_addr_t wb_rdc,
  output logic      hazard,
  output logic      fwd
);

  logic pending;
  logic retiring;

  // x0 is hardwired, so it never waits on anything.
  assign pending  = use_addr & (addr != '0) & busy_vec[addr];
  assign retiring = wb_valid & (wb_rdc == addr);

  assign hazard = pending & ~(BYPASS & retiring);
  assign fwd    = BYPASS & pending & retiring;

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-stage scoreboard for the 32x64 register file: tracks in-flight multi-cycle
// writes, gates issue on RAW/WAW/capacity hazards and flags writeback bypass.
module regfile_scoreboard
  import regfile_scoreboard_pkg::reg_addr_t;
  import regfile_scoreboard_pkg::busy_vec_t;
  import regfile_scoreboard_pkg::count_t;
  import regfile_scoreboard_pkg::is_tracked;
#(
  parameter int NREG            = 32,
  parameter bit BYPASS_WB       = 1'b1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_scoreboard_if.slave   sb,
  output busy_vec_t             busy_vec,
  output count_t                outstanding
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  count_t          count_q;
  count_t          count_d;

  logic raw1, raw2, waw, cap;
  logic fire, set, wb_clr;
  logic unused_rd_fwd;

  regfile_scoreboard_hazard #(.BYPASS(BYPASS_WB)) u_rs1 (
    .addr     (sb.iss_rs1c),
    .use_addr (sb.iss_use_rs1),
    .busy_vec (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rdc   (sb.wb_rdc),
    .hazard   (raw1),
    .fwd      (sb.fwd_rs1)
  );

  regfile_scoreboard_hazard #(.BYPASS(BYPASS_WB)) u_rs2 (
    .addr     (sb.iss_rs2c),
    .use_addr (sb.iss_use_rs2),
    .busy_vec (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rdc   (sb.wb_rdc),
    .hazard   (raw2),
    .fwd      (sb.fwd_rs2)
  );

  // A retiring write to rd always clears before the new set lands, so WAW
  // resolves on same-cycle writeback regardless of the operand bypass setting.
  regfile_scoreboard_hazard #(.BYPASS(1'b1)) u_rd (
    .addr     (sb.iss_rdc),
    .use_addr (sb.iss_wen),
    .busy_vec (busy_q),
    .wb_valid (sb.wb_valid),
    .wb_rdc   (sb.wb_rdc),
    .hazard   (waw),
    .fwd      (unused_rd_fwd)
  );

  assign wb_clr = sb.wb_valid & busy_q[sb.wb_rdc];
  assign cap    = is_tracked(sb.iss_wen, sb.iss_long, sb.iss_rdc)
                & (count_q == count_t'(MAX_OUTSTANDING)) & ~wb_clr;

  assign sb.iss_ready = ~(raw1 | raw2 | waw | cap | sb.flush);
  assign fire         = sb.iss_valid & sb.iss_ready;
  assign set          = fire & is_tracked(sb.iss_wen, sb.iss_long, sb.iss_rdc);

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    busy_d = busy_q;
    if (wb_clr) busy_d[sb.wb_rdc] = 1'b0;
    if (set)    busy_d[sb.iss_rdc] = 1'b1;
    count_d = count_q + count_t'(set) - count_t'(wb_clr);
  end

  // NOTE: the busy vector is a handful of flops, not a RAM, so it takes the reset
  // directly; state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else if (sb.flush) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_vec    = busy_q;
  assign outstanding = count_q;

  a_busy_consistent: assert property (@(posedge clk) disable iff (!rst)
    ($countones(busy_q) == int'(count_q)) && !busy_q[0]);

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed table-driven bench for regfile_scoreboard plus a bounded stall/retire sequence.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  busy_vec_t busy_vec;
  count_t    outstanding;

  regfile_scoreboard_if sb();

  regfile_scoreboard #(.NREG(32), .BYPASS_WB(1'b1), .MAX_OUTSTANDING(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sb          (sb),
    .busy_vec    (busy_vec),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        valid;
    int          rs1;
    logic        u1;
    int          rs2;
    logic        u2;
    int          rd;
    logic        wen;
    logic        lng;
    logic        wbv;
    int          wbrd;
    logic        fl;
    logic        chk;
    logic        rdy;
    logic        f1;
    logic        f2;
    logic [31:0] busy;
    int          outs;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(string name, logic rst_n, logic valid, int rs1, logic u1,
                             int rs2, logic u2, int rd, logic wen, logic lng, logic wbv,
                             int wbrd, logic fl, logic chk, logic rdy, logic f1, logic f2,
                             logic [31:0] busy, int outs);
    vec_t t;
    t.name = name; t.rst_n = rst_n; t.valid = valid; t.rs1 = rs1; t.u1 = u1;
    t.rs2 = rs2; t.u2 = u2; t.rd = rd; t.wen = wen; t.lng = lng; t.wbv = wbv;
    t.wbrd = wbrd; t.fl = fl; t.chk = chk; t.rdy = rdy; t.f1 = f1; t.f2 = f2;
    t.busy = busy; t.outs = outs;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst            = t.rst_n;
    sb.iss_valid   = t.valid;
    sb.iss_rs1c    = reg_addr_t'(t.rs1);
    sb.iss_use_rs1 = t.u1;
    sb.iss_rs2c    = reg_addr_t'(t.rs2);
    sb.iss_use_rs2 = t.u2;
    sb.iss_rdc     = reg_addr_t'(t.rd);
    sb.iss_wen     = t.wen;
    sb.iss_long    = t.lng;
    sb.wb_valid    = t.wbv;
    sb.wb_rdc      = reg_addr_t'(t.wbrd);
    sb.flush       = t.fl;
  endtask

  task automatic apply(vec_t t);
    @(negedge clk);
    drive(t);
    #1;
    if (t.chk) begin
      check({t.name, ".iss_ready"}, 32'(sb.iss_ready), 32'(t.rdy));
      check({t.name, ".fwd_rs1"},   32'(sb.fwd_rs1),   32'(t.f1));
      check({t.name, ".fwd_rs2"},   32'(sb.fwd_rs2),   32'(t.f2));
    end
    @(posedge clk);
    #1;
    check({t.name, ".busy_vec"},    busy_vec,          t.busy);
    check({t.name, ".outstanding"}, 32'(outstanding),  32'(t.outs));
  endtask

  localparam logic [31:0] B1 = 32'h2, B2 = 32'h4, B3 = 32'h8, B4 = 32'h10;
  localparam logic [31:0] B5 = 32'h20, B7 = 32'h80, B11 = 32'h800, B12 = 32'h1000;

  initial begin
    int   stall;
    logic fwd_seen;
    vec_t idle;

    idle = v("idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    drive(v("init", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    //                 name           rst vld rs1 u1 rs2 u2 rd wen lng wbv wbrd fl chk rdy f1 f2 busy            outs
    vecs.push_back(v("rst0",        0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,              0));
    vecs.push_back(v("rst1",        0, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("idle0",       1, 0,  0, 0,  0, 0,  0, 0, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("plain",       1, 1,  5, 1,  6, 1,  8, 1, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("long7",       1, 1,  1, 1,  0, 0,  7, 1, 1,  0,  0, 0, 1, 1, 0, 0, B7,             1));
    vecs.push_back(v("raw7a",       1, 1,  7, 1,  0, 0, 10, 1, 0,  0,  0, 0, 1, 0, 0, 0, B7,             1));
    vecs.push_back(v("raw7b",       1, 1,  7, 1,  0, 0, 10, 1, 0,  0,  0, 0, 1, 0, 0, 0, B7,             1));
    vecs.push_back(v("raw7wb",      1, 1,  7, 1,  0, 0, 10, 1, 0,  1,  7, 0, 1, 1, 1, 0, 0,              0));
    vecs.push_back(v("raw7after",   1, 1,  7, 1,  0, 0,  0, 0, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("long11",      1, 1,  0, 0,  0, 0, 11, 1, 1,  0,  0, 0, 1, 1, 0, 0, B11,            1));
    vecs.push_back(v("raw11rs2",    1, 1, 11, 0, 11, 1,  0, 0, 0,  0,  0, 0, 1, 0, 0, 0, B11,            1));
    vecs.push_back(v("fwd11rs2",    1, 1, 11, 0, 11, 1,  0, 0, 0,  1, 11, 0, 1, 1, 0, 1, 0,              0));
    vecs.push_back(v("long3",       1, 1,  0, 0,  0, 0,  3, 1, 1,  0,  0, 0, 1, 1, 0, 0, B3,             1));
    vecs.push_back(v("waw3",        1, 1,  0, 0,  0, 0,  3, 1, 0,  0,  0, 0, 1, 0, 0, 0, B3,             1));
    vecs.push_back(v("waw3wb",      1, 1,  0, 0,  0, 0,  3, 1, 1,  1,  3, 0, 1, 1, 0, 0, B3,             1));
    vecs.push_back(v("wb3",         1, 0,  0, 0,  0, 0,  0, 0, 0,  1,  3, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("cap1",        1, 1,  0, 0,  0, 0,  1, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1,             1));
    vecs.push_back(v("cap2",        1, 1,  0, 0,  0, 0,  2, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1|B2,          2));
    vecs.push_back(v("cap3",        1, 1,  0, 0,  0, 0,  3, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1|B2|B3,       3));
    vecs.push_back(v("cap4",        1, 1,  0, 0,  0, 0,  4, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1|B2|B3|B4,    4));
    vecs.push_back(v("cap5stall",   1, 1,  0, 0,  0, 0,  5, 1, 1,  0,  0, 0, 1, 0, 0, 0, B1|B2|B3|B4,    4));
    vecs.push_back(v("cap5wb2",     1, 1,  0, 0,  0, 0,  5, 1, 1,  1,  2, 0, 1, 1, 0, 0, B1|B3|B4|B5,    4));
    vecs.push_back(v("cap_short",   1, 1,  0, 0,  0, 0,  6, 1, 0,  0,  0, 0, 1, 1, 0, 0, B1|B3|B4|B5,    4));
    vecs.push_back(v("flush_full",  1, 1,  0, 0,  0, 0,  9, 1, 1,  1,  1, 1, 1, 0, 0, 0, 0,              0));
    vecs.push_back(v("x0long",      1, 1,  0, 1,  0, 0,  0, 1, 1,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("stray9",      1, 0,  0, 0,  0, 0,  0, 0, 0,  1,  9, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("fl_set1",     1, 1,  0, 0,  0, 0,  1, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1,             1));
    vecs.push_back(v("fl_set2",     1, 1,  0, 0,  0, 0,  2, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1|B2,          2));
    vecs.push_back(v("flush_wb1",   1, 1,  9, 1,  0, 0,  0, 0, 0,  1,  1, 1, 1, 0, 0, 0, 0,              0));
    vecs.push_back(v("post_flush",  1, 1,  1, 1,  2, 1,  0, 0, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("rs_set1",     1, 1,  0, 0,  0, 0,  1, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1,             1));
    vecs.push_back(v("rs_set2",     1, 1,  0, 0,  0, 0,  2, 1, 1,  0,  0, 0, 1, 1, 0, 0, B1|B2,          2));
    vecs.push_back(v("rst_mid",     0, 1,  0, 0,  0, 0,  7, 1, 1,  1,  1, 0, 0, 0, 0, 0, 0,              0));
    vecs.push_back(v("post_rst",    1, 1,  1, 1,  2, 1,  0, 0, 0,  0,  0, 0, 1, 1, 0, 0, 0,              0));
    vecs.push_back(v("long12",      1, 1,  0, 0,  0, 0, 12, 1, 1,  0,  0, 0, 1, 1, 0, 0, B12,            1));
    vecs.push_back(v("stray13",     1, 0,  0, 0,  0, 0,  0, 0, 0,  1, 13, 0, 1, 1, 0, 0, B12,            1));
    vecs.push_back(v("fwd12both",   1, 1, 12, 1, 12, 1,  0, 0, 0,  1, 12, 0, 1, 1, 1, 1, 0,              0));

    foreach (vecs[i]) apply(vecs[i]);

    // Hold a reader of x20 and retire x20 on the fourth try; ready must appear exactly then.
    apply(v("long20", 1, 1, 0, 0, 0, 0, 20, 1, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0010_0000, 1));
    stall    = -1;
    fwd_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(v("rd20", 1, 1, 20, 1, 0, 0, 0, 0, 0, (c == 3), 20, 0, 0, 0, 0, 0, 0, 0));
      #1;
      if (sb.iss_ready) begin
        stall    = c;
        fwd_seen = sb.fwd_rs1;
        break;
      end
    end
    check("rd20.ready_cycle", 32'(stall), 32'd3);
    check("rd20.fwd_rs1", 32'(fwd_seen), 32'd1);
    @(posedge clk);
    #1;
    check("rd20.busy_vec", busy_vec, 32'h0);
    check("rd20.outstanding", 32'(outstanding), 32'd0);

    apply(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
